mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL provide parameter DATA_W, default 32, LSU load/store data width.
REQ-003 SHALL provide parameter BUNDLE_W, default 128, instruction bundle width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 if_req  input  1  fetch requests a bundle read; held until if_done.
REQ-007 if_addr  input  ADDR_W  fetch PC.
REQ-008 if_squash  input  1  branch squash; cancels delivery of an in-flight fetch.
REQ-009 if_done  output  1  one-cycle pulse; if_bundle valid.
REQ-010 if_bundle  output  BUNDLE_W  returned bundle.
REQ-011 lsu_req  input  1  LSU access request; held until lsu_done.
REQ-012 lsu_we  input  1  1 = store, 0 = load.
REQ-013 lsu_addr  input  ADDR_W  data address.
REQ-014 lsu_wdata  input  DATA_W  store data.
REQ-015 lsu_done  output  1  one-cycle pulse; access complete, lsu_rdata valid for loads.
REQ-016 lsu_rdata  output  DATA_W  load data.
REQ-017 mem_req  output  1  one-cycle command strobe to the single memory port.
REQ-018 mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DATA_W  command fields, held stable from mem_req until mem_ack.
REQ-019 mem_is_fetch  output  1  command is a bundle read.
REQ-020 mem_ack  input  1  memory completion strobe, latency >= 1 cycle after mem_req.
REQ-021 mem_rdata  input  BUNDLE_W  read data, valid with mem_ack; LSU uses bits [DATA_W-1:0].
REQ-022 busy  output  1  high in any state other than IDLE.

Function
REQ-023 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-024 IDLE: if any request is present, SHALL latch the winner's id, address, we and wdata into command registers and go to ISSUE; otherwise remain in IDLE.
REQ-025 ISSUE: SHALL assert mem_req for exactly one cycle, then go to WAIT.
REQ-026 WAIT: on mem_ack, SHALL capture mem_rdata and go to DONE; otherwise hold the command fields unchanged.
REQ-027 DONE: SHALL pulse the winner's done for one cycle with registered data, then go to IDLE.
REQ-028 Latency: request sampled at edge N gives mem_req at N+1, and mem_ack at edge M gives done at M+1; minimum 4 cycles from request to done.
REQ-029 Simultaneous if_req and lsu_req in IDLE: LSU SHALL win (fixed priority) unless REQ-036 is in effect.
REQ-030 A requester dropping req after its grant SHALL NOT abort the transaction; it completes, and done pulses.
REQ-031 if_squash high during any non-IDLE cycle of a fetch transaction SHALL suppress that if_done pulse; the memory transaction still completes and the FSM still returns to IDLE.
REQ-032 if_squash SHALL have no effect on LSU transactions.
REQ-033 mem_ack in IDLE, ISSUE or DONE SHALL be ignored.
REQ-034 if_done and lsu_done SHALL never be high in the same cycle.

Reset
REQ-035 With rst high at an edge, the FSM SHALL enter IDLE; mem_req, if_done, lsu_done and busy SHALL be 0; all data and command registers SHALL be 0; the round-robin pointer SHALL select LSU. This holds mid-transaction: no done pulse is produced, and a later mem_ack is ignored per REQ-033.

Configuration
REQ-036 With macro MEM_ARB_ROUND_ROBIN_EN defined, a simultaneous-request tie SHALL go to the requester not granted most recently, and the pointer SHALL update when the FSM enters ISSUE. Without the macro, REQ-029 fixed priority applies and no pointer register exists.

Verification
REQ-037 rst, then if_req=1, if_addr=0x40, mem_ack 2 cycles after mem_req, mem_rdata=0xA..A -> mem_is_fetch=1, mem_addr=0x40, one if_done pulse with if_bundle=0xA..A.
REQ-038 lsu_req=1, lsu_we=1, lsu_addr=0x100, lsu_wdata=0xDEADBEEF -> mem_we=1 with fields held until mem_ack, then one lsu_done pulse; if_done stays 0.
REQ-039 if_req and lsu_req high together for 3 back-to-back transactions -> without the macro LSU, LSU, LSU; with MEM_ARB_ROUND_ROBIN_EN defined LSU, IF, LSU.
REQ-040 Fetch in WAIT, if_squash pulsed, then mem_ack -> no if_done, busy drops to 0 one cycle after DONE, and a pending lsu_req is issued next.
REQ-041 rst asserted in WAIT, then mem_ack one cycle later -> outputs stay at reset values, with no done pulse and no mem_req.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the LSU; MEM_ARB_ROUND_ROBIN_EN enables round-robin tie-breaking
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BUNDLE_W = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_squash,
    output logic                if_done,
    output logic [BUNDLE_W-1:0] if_bundle,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    output logic                lsu_done,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_is_fetch,
    input  logic                mem_ack,
    input  logic [BUNDLE_W-1:0] mem_rdata,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic cmd_fetch, cmd_we, squashed, grant, pick_lsu;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BUNDLE_W-1:0] rdata_q;
    assign grant = if_req || lsu_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_lsu;
    assign pick_lsu = lsu_req && (!if_req || rr_lsu);
    // tie-break pointer: favour whichever requester was not granted last
    always_ff @(posedge clk) begin
        if (rst) rr_lsu <= 1'b1;
        else if (state == IDLE && grant) rr_lsu <= !pick_lsu;
    end
`else
    assign pick_lsu = lsu_req;
`endif
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end
    // next state and strobes; a squash seen in the done cycle itself also cancels delivery
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = mem_ack ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
        mem_req  = state == ISSUE;
        busy     = state != IDLE;
        if_done  = state == DONE && cmd_fetch && !squashed && !if_squash;
        lsu_done = state == DONE && !cmd_fetch;
    end
    // command latch at grant, squash tracking, read data capture on ack
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_fetch <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            squashed  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE && grant) begin
                cmd_fetch <= !pick_lsu;
                cmd_we    <= pick_lsu && lsu_we;
                cmd_addr  <= pick_lsu ? lsu_addr : if_addr;
                cmd_wdata <= pick_lsu ? lsu_wdata : '0;
                squashed  <= 1'b0;
            end else if (state != IDLE && if_squash) begin
                squashed <= 1'b1;
            end
            if (state == WAIT && mem_ack) rdata_q <= mem_rdata;
        end
    end
    assign mem_we       = cmd_we;
    assign mem_addr     = cmd_addr;
    assign mem_wdata    = cmd_wdata;
    assign mem_is_fetch = cmd_fetch;
    assign if_bundle    = rdata_q;
    assign lsu_rdata    = rdata_q[DATA_W-1:0];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a memory responder
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst;
    logic if_req, if_squash, if_done, lsu_req, lsu_we, lsu_done;
    logic mem_req, mem_we, mem_is_fetch, mem_ack, busy;
    logic [31:0] if_addr, lsu_addr, lsu_wdata, lsu_rdata, mem_addr, mem_wdata;
    logic [127:0] if_bundle, mem_rdata;
    typedef struct packed {logic f; logic we; logic [31:0] a; logic [31:0] wd;} cmd_t;
    typedef struct packed {logic f; logic chk; logic [127:0] d;} done_t;
    cmd_t cq[$];
    done_t dq[$];
    int n_chk = 0, n_fail = 0, ack_lat = 2, cnt = 0;
    logic auto_ack = 1'b1, man_ack = 1'b0, hold = 1'b0;
    logic [127:0] rsp_data = '0;
    cmd_t c, cap;
    done_t d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic [2:0] ARB_F = 3'b010;
`else
    localparam logic [2:0] ARB_F = 3'b000;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_squash(if_squash),
        .if_done(if_done), .if_bundle(if_bundle), .lsu_req(lsu_req), .lsu_we(lsu_we),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_is_fetch(mem_is_fetch), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic wait_for(input int sel, input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((sel == 0 && mem_req) || (sel == 1 && if_done) || (sel == 2 && lsu_done) ||
                (sel == 3 && mem_ack) || (sel == 4 && (if_done || lsu_done))) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out after 60 cycles, required event never seen", nm);
    endtask

    // monitor (negedge) and memory responder (just after posedge)
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("held addr", mem_addr, cap.a);
                chk("held we", mem_we, cap.we);
                chk("held wdata", mem_wdata, cap.wd);
                chk("held is_fetch", mem_is_fetch, cap.f);
                if (mem_ack) hold = 1'b0;
            end
            if (mem_req) begin
                if (cq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected mem_req: addr %0h, none required", mem_addr);
                end else begin
                    c = cq.pop_front();
                    chk("cmd is_fetch", mem_is_fetch, c.f);
                    chk("cmd we", mem_we, c.we);
                    chk("cmd addr", mem_addr, c.a);
                    if (c.we) chk("cmd wdata", mem_wdata, c.wd);
                end
                cap = '{mem_is_fetch, mem_we, mem_addr, mem_wdata};
                if (auto_ack) begin
                    cnt = ack_lat;
                    hold = 1'b1;
                end
            end
            if (if_done || lsu_done) begin
                chk("done exclusive", if_done && lsu_done, 0);
                if (dq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected done: if_done %0b lsu_done %0b, none required", if_done, lsu_done);
                end else begin
                    d = dq.pop_front();
                    chk("done is_fetch", if_done, d.f);
                    if (d.chk) chk("done data", if_done ? if_bundle : {96'h0, lsu_rdata}, d.d);
                end
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            mem_rdata = '0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = rsp_data;
                end
            end else if (man_ack) begin
                mem_ack = 1'b1;
                mem_rdata = rsp_data;
            end
        end
    end

    // directed stimulus
    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_squash = 1'b0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst if_done", if_done, 0);
        chk("rst lsu_done", lsu_done, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst if_bundle", if_bundle, 0);
        @(posedge clk); #1 rst = 1'b0;
        // fetch, ack two cycles after mem_req
        ack_lat = 2; rsp_data = {4{32'hAAAAAAAA}};
        cq.push_back('{1'b1, 1'b0, 32'h40, 32'h0});
        dq.push_back('{1'b1, 1'b1, {4{32'hAAAAAAAA}}});
        if_addr = 32'h40; if_req = 1'b1;
        wait_for(1, "fetch done");
        @(posedge clk); #1 if_req = 1'b0;
        // store held across a three-cycle wait
        ack_lat = 3; rsp_data = {4{32'h0F0F0F0F}};
        cq.push_back('{1'b0, 1'b1, 32'h100, 32'hDEADBEEF});
        dq.push_back('{1'b0, 1'b0, 128'h0});
        lsu_addr = 32'h100; lsu_wdata = 32'hDEADBEEF; lsu_we = 1'b1; lsu_req = 1'b1;
        wait_for(2, "store done");
        @(posedge clk); #1 lsu_req = 1'b0; lsu_we = 1'b0;
        // load at minimum latency
        ack_lat = 1; rsp_data = {4{32'hCAFEF00D}};
        cq.push_back('{1'b0, 1'b0, 32'h104, 32'h0});
        dq.push_back('{1'b0, 1'b1, {96'h0, 32'hCAFEF00D}});
        lsu_addr = 32'h104; lsu_req = 1'b1;
        begin
            int n = 0;
            while (!lsu_done && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("load latency cycles", n, 4);
        end
        @(posedge clk); #1 lsu_req = 1'b0;
        // squashed fetch, then a pending load
        ack_lat = 3; rsp_data = {4{32'h13572468}};
        cq.push_back('{1'b1, 1'b0, 32'h80, 32'h0});
        cq.push_back('{1'b0, 1'b0, 32'h120, 32'h0});
        dq.push_back('{1'b0, 1'b1, {96'h0, 32'h13572468}});
        if_addr = 32'h80; if_req = 1'b1;
        wait_for(0, "squash fetch issue");
        @(posedge clk); #1 if_squash = 1'b1; if_req = 1'b0; lsu_addr = 32'h120; lsu_req = 1'b1;
        @(posedge clk); #1 if_squash = 1'b0;
        wait_for(3, "squash fetch ack");
        @(negedge clk);
        chk("squash done-cycle busy", busy, 1);
        chk("squash if_done", if_done, 0);
        @(negedge clk);
        chk("squash busy after done", busy, 0);
        wait_for(2, "load after squash");
        @(posedge clk); #1 lsu_req = 1'b0;
        // reset during WAIT, stray ack afterwards
        auto_ack = 1'b0; rsp_data = {4{32'h55555555}};
        cq.push_back('{1'b1, 1'b0, 32'h60, 32'h0});
        if_addr = 32'h60; if_req = 1'b1;
        wait_for(0, "reset fetch issue");
        @(posedge clk); #1 rst = 1'b1; if_req = 1'b0;
        @(negedge clk) man_ack = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk) man_ack = 1'b0;
        chk("post-rst mem_ack present", mem_ack, 1);
        for (int i = 0; i < 3; i++) begin
            chk("post-rst busy", busy, 0);
            chk("post-rst mem_req", mem_req, 0);
            chk("post-rst if_bundle", if_bundle, 0);
            chk("post-rst mem_addr", mem_addr, 0);
            @(negedge clk);
        end
        auto_ack = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        // simultaneous requests, three back-to-back grants
        ack_lat = 1; rsp_data = {4{32'h12345678}};
        for (int i = 0; i < 3; i++) begin
            cq.push_back(ARB_F[i] ? cmd_t'{1'b1, 1'b0, 32'h200, 32'h0} : cmd_t'{1'b0, 1'b0, 32'h300, 32'h0});
            dq.push_back(ARB_F[i] ? done_t'{1'b1, 1'b1, {4{32'h12345678}}} : done_t'{1'b0, 1'b1, {96'h0, 32'h12345678}});
        end
        if_addr = 32'h200; lsu_addr = 32'h300; if_req = 1'b1; lsu_req = 1'b1;
        for (int i = 0; i < 3; i++) wait_for(4, "arbitration done");
        @(posedge clk); #1 if_req = 1'b0; lsu_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("cmd queue drained", cq.size(), 0);
        chk("done queue drained", dq.size(), 0);
        chk("final busy", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
